mem_port_arbiter: RTL

//  Shares the single-port Memoria between two requesters:
//   - port 0 (cpu_*): the multicycle datapath's IorD-muxed access;
//   - port 1 (dbg_*): the program loader / debug port.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port Memoria: round-robin grant on ties,
// read latency sequencing to MEM_LAT, and a one-cycle ack per completed access.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  // Handshake: a requester raises req with wr/addr/wdata and keeps it high until
  // its ack pulse; requests are only sampled in IDLE, and everything is latched
  // on grant, so inputs may change (or req may drop) once the grant has happened.

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // A lone dbg_req selects port 1; on a tie the port not served last wins.
    grant        = (cpu_req && dbg_req) ? ~last_owner_q : dbg_req;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d      = grant;
          last_owner_d = grant;
          wr_d         = grant ? dbg_wr    : cpu_wr;
          addr_d       = grant ? dbg_addr  : cpu_addr;
          wdata_d      = grant ? dbg_wdata : cpu_wdata;
          cnt_d        = 3'd1;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_RESP;
        end else if (cnt_q == LAT3) begin
          if (owner_q) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_wr    = (state_q == S_ACCESS) && wr_q;
  assign cpu_ack   = (state_q == S_RESP) && !owner_q;
  assign dbg_ack   = (state_q == S_RESP) && owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign fsm_state = state_q;

endmodule
